// File: rtl/dmem_verify_pkg.sv
// Shared types and defaults for the data-memory end-of-program verify engine.
package dmem_verify_pkg;

  typedef enum logic [1:0] {StRun, StSettle, StScan, StDone} dmem_state_e;

  localparam int unsigned DefaultDepth        = 1024;
  localparam int unsigned DefaultHaltAddr     = 32;
  localparam int unsigned DefaultSettleCycles = 5;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_scan_cmp.sv
// Scan index counter and word comparator; advances only while enabled and matching.
module dmem_scan_cmp
  import dmem_verify_pkg::*;
#(
  parameter int unsigned DEPTH  = DefaultDepth,
  parameter int unsigned DATA_W = 32
) (
  input  logic                        clock,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [DATA_W-1:0]           data_read,
  input  logic [DATA_W-1:0]           golden_data,
  output logic [idx_width(DEPTH)-1:0] index,
  output logic                        match,
  output logic                        last,
  output logic                        mismatch
);

  localparam int unsigned IdxW = idx_width(DEPTH);

  assign match    = (data_read == golden_data);
  assign last     = (index == IdxW'(DEPTH - 1));
  assign mismatch = en & ~match;

  // Index is never cleared on scan entry: only reset clears it and only scanning moves it.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      index <= '0;
    end else if (en && match && !last) begin
      index <= index + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_verify_engine.sv
// End-of-program checker: times the run to HALT_ADDR, settles, then sweeps data memory vs golden.
// Optional watchdog build: define DMEM_VERIFY_WATCHDOG_EN (adds the timeout output).
module dmem_verify_engine
  import dmem_verify_pkg::*;
#(
  parameter int unsigned       DEPTH         = DefaultDepth,
  parameter int unsigned       DATA_W        = 32,
  parameter int unsigned       ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR     = ADDR_W'(DefaultHaltAddr),
  parameter int unsigned       SETTLE_CYCLES = DefaultSettleCycles,
  parameter int unsigned       MAX_LATENCY   = 100000
) (
  input  logic                        clock,
  input  logic                        rst_n,
  input  logic [ADDR_W-1:0]           inst_addr,
  input  logic [DATA_W-1:0]           data_read,
  input  logic [DATA_W-1:0]           golden_data,
  output logic                        mem_sel,
  output logic [ADDR_W-1:0]           data_addr,
  output logic                        data_wen,
  output logic [idx_width(DEPTH)-1:0] golden_addr,
  output logic                        done,
  output logic                        pass,
  output logic [idx_width(DEPTH)-1:0] fail_addr,
`ifdef DMEM_VERIFY_WATCHDOG_EN
  output logic                        timeout,
`endif
  output logic [31:0]                 latency
);

  localparam int unsigned IdxW = idx_width(DEPTH);

  if (SETTLE_CYCLES == 0 || MAX_LATENCY >= 32'hFFFF_FFFF) begin : g_param_chk
    $error("dmem_verify_engine: SETTLE_CYCLES must be >= 1 and MAX_LATENCY < 2^32-1");
  end

  dmem_state_e     state_q;
  logic [31:0]     settle_q;
  logic [31:0]     lat_inc;
  logic [IdxW-1:0] idx;
  logic            scan_en;
  logic            match;
  logic            last;
  logic            mismatch;

  assign scan_en     = (state_q == StScan);
  assign data_addr   = ADDR_W'(idx);
  assign golden_addr = idx;
  assign data_wen    = 1'b0;
  assign lat_inc     = (latency == '1) ? latency : latency + 32'd1;

  dmem_scan_cmp #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_scan_cmp (
    .clock       (clock),
    .rst_n       (rst_n),
    .en          (scan_en),
    .data_read   (data_read),
    .golden_data (golden_data),
    .index       (idx),
    .match       (match),
    .last        (last),
    .mismatch    (mismatch)
  );

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q   <= StRun;
      settle_q  <= '0;
      mem_sel   <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      latency   <= '0;
`ifdef DMEM_VERIFY_WATCHDOG_EN
      timeout   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StRun: begin
          if (inst_addr == HALT_ADDR) begin
            state_q  <= StSettle;
            settle_q <= '0;
          end else begin
            latency <= lat_inc;
`ifdef DMEM_VERIFY_WATCHDOG_EN
            if (lat_inc == MAX_LATENCY + 32'd1) begin
              state_q   <= StDone;
              done      <= 1'b1;
              pass      <= 1'b0;
              fail_addr <= '1;
              timeout   <= 1'b1;
            end
`endif
          end
        end
        StSettle: begin
          // Halt is latched here; inst_addr no longer matters.
          if (settle_q == SETTLE_CYCLES - 1) begin
            state_q <= StScan;
            mem_sel <= 1'b1;
          end else begin
            settle_q <= settle_q + 32'd1;
          end
        end
        StScan: begin
          if (mismatch) begin
            state_q   <= StDone;
            done      <= 1'b1;
            pass      <= 1'b0;
            fail_addr <= idx;
          end else if (match && last) begin
            state_q <= StDone;
            done    <= 1'b1;
            pass    <= 1'b1;
          end
        end
        StDone: begin
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_verify_engine.md
# dmem_verify_engine

Hardware end-of-program checker acting as a second initiator on the single-cycle CPU's data-memory port. It tracks execution latency until the CPU fetches from the halt address, waits a settle window, then takes over the data-memory read port. It sweeps every word, compares each against a golden-image ROM, and reports pass/fail, the first mismatching address and the execution cycle count.

## Interface
- DEPTH, 1024, words in data memory and golden ROM
- DATA_W, 32, data word width
- ADDR_W, 32, memory address bus width
- HALT_ADDR, 32, instruction address that marks program completion
- SETTLE_CYCLES, 5, idle cycles between halt detection and scan start
- MAX_LATENCY, 100000, watchdog limit (used only with the watchdog macro)
- clock  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- inst_addr  in  ADDR_W  CPU instruction fetch address (monitored only)
- data_read  in  DATA_W  combinational read data from data memory at data_addr
- golden_data  in  DATA_W  combinational golden ROM word at golden_addr
- mem_sel  out  1  1 = engine owns data-memory port (top-level mux select)
- data_addr  out  ADDR_W  engine read address (zero-extended scan index)
- data_wen  out  1  write enable, held 0 (engine never writes)
- golden_addr  out  $clog2(DEPTH)  golden ROM index, equals scan index
- done  out  1  check finished (sticky until reset)
- pass  out  1  valid with done; 1 = all words matched
- fail_addr  out  $clog2(DEPTH)  first mismatching index, valid when done & !pass
- latency  out  32  cycles spent in RUN before halt detected

## Operation
- FSM states: RUN, SETTLE, SCAN, DONE. Reset state RUN.
- RUN: each cycle with inst_addr != HALT_ADDR, latency += 1 (saturating at 2^32-1). On inst_addr == HALT_ADDR: latency not incremented, go SETTLE, settle counter = 0.
- SETTLE: counter increments each cycle; after SETTLE_CYCLES cycles go SCAN, index = 0. inst_addr ignored (halt is latched; leaving HALT_ADDR has no effect).
- SCAN: mem_sel = 1, data_addr = golden_addr = index. Compare data_read vs golden_data in the same cycle.
  - Mismatch: fail_addr = index, pass = 0, go DONE.
  - Match and index == DEPTH-1: pass = 1, go DONE.
  - Match otherwise: index += 1.
- DONE: terminal; mem_sel stays 1, outputs frozen until rst_n.
- Comparison is full DATA_W bitwise; any X/Z on inputs treated as ordinary bits (no special handling).
- Reset values: state RUN, mem_sel 0, data_addr 0, data_wen 0, golden_addr 0, done 0, pass 0, fail_addr 0, latency 0.
- Reset asserted in any state, including mid-SCAN, returns to RUN with all counters and outputs cleared at that edge.

## Timing
- Halt sampled on edge N (in RUN) -> state SETTLE from N; SCAN entered SETTLE_CYCLES edges later.
- Full-pass scan: DEPTH cycles in SCAN; done/pass rise on the edge that evaluates index DEPTH-1.
- Mismatch at index k: done rises on the (k+1)th SCAN edge.
- Total cycles reset-release to done (pass case) = latency + 1 + SETTLE_CYCLES + DEPTH.
- mem_sel is registered; asserts on the edge entering SCAN, so the CPU loses the port from the first scan cycle.

## Configuration
- DMEM_VERIFY_WATCHDOG_EN defined: in RUN, when latency reaches MAX_LATENCY+1 without halt, go DONE with pass = 0, fail_addr = all-ones, and extra output timeout = 1 (reset 0). The timeout port exists only with the macro.
- Undefined: no watchdog, RUN waits indefinitely, MAX_LATENCY unused.

## Structure
- Shared package dmem_verify_pkg: state enum (RUN, SETTLE, SCAN, DONE), default DEPTH/HALT_ADDR/SETTLE_CYCLES constants, index width function.
- One natural sub-module: dmem_scan_cmp (index counter plus comparator, emits match/last/mismatch flags); FSM and latency counter stay in top.

## Test plan
- Halt at cycle 10, memory equal to golden -> latency = 10, done = 1, pass = 1 at reset-release + 1040 cycles.
- Word 517 differs (0xDEADBEEF vs 0x0) -> done = 1, pass = 0, fail_addr = 517, done at scan cycle 518.
- Boundary mismatches at index 0 and separately at 1023 -> fail_addr 0 (first SCAN cycle) and 1023 (last SCAN cycle).
- inst_addr hits 32 for one cycle then moves to 36 -> still SETTLE then SCAN; latency frozen at the halt value.
- rst_n low for 1 cycle at scan index 300 -> all outputs 0, mem_sel 0, state RUN, latency restarts from 0.
- With DMEM_VERIFY_WATCHDOG_EN and MAX_LATENCY = 100, never halt -> timeout = 1, done = 1, pass = 0 after 101 RUN cycles.
